mc_controller: RTL and testbench

Multicycle control unit for the MIPS core: a Moore FSM that sequences one shared ALU, register file and unified instruction/data memory through fetch, decode, execute, memory and writeback steps. It sits beside the multicycle datapath, decodes `op`/`funct` from the instruction register and drives every mux select, register enable and memory strobe. A memory-ready handshake lets it stall on slow memory.

---
 rtl/mc_controller_pkg.sv | 65 ++++++
 rtl/mc_controller_alu_decoder.sv | 30 +++
 rtl/mc_controller.sv | 158 +++++++++++++++
 tb/tb_mc_controller.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mc_controller_pkg.sv
// Shared constants for the multicycle MIPS control unit: opcodes, functs, ALU codes, state encoding.
// Optional bne support is enabled by defining MC_BNE_EN.
package mc_controller_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

`ifdef MC_BNE_EN
    localparam logic BNE_EN = 1'b1;
`else
    localparam logic BNE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQ     = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
`ifdef MC_BNE_EN
        , S_BNE   = 4'd12
`endif
    } state_e;

    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
            OP_BNE:  ok = BNE_EN;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// ALU control decode: fixed add/sub for address and branch work, funct field for R-type.
module alu_decoder
    import mc_controller_pkg::*;
(
    input  aluop_e      aluop,
    input  logic [5:0]  funct,
    output logic [2:0]  alucontrol
);

    // Unknown functs and the unused aluop code fall back to add without flagging anything.
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Moore control FSM for the multicycle MIPS datapath with memory-ready stalls.
// Define MC_BNE_EN to add the bne instruction (state BNE).
module mc_controller
    import mc_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        iord,
    output logic        memwrite,
    output logic        irwrite,
    output logic        pcen,
    output logic        regwrite,
    output logic        memtoreg,
    output logic        regdst,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic [2:0]  alucontrol,
    output logic        illegal_op
);

    state_e state_q, state_d;
    aluop_e aluop_s;
    logic   mem_req_s, memwrite_s, irwrite_s, regwrite_s, pcwrite_s;
    logic   branch_s, branch_ne_s, illegal_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = S_BNE;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Raw per-state outputs; strobes are qualified by reset below.
    always_comb begin
        mem_req_s   = 1'b0;
        iord        = 1'b0;
        memwrite_s  = 1'b0;
        irwrite_s   = 1'b0;
        pcwrite_s   = 1'b0;
        regwrite_s  = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        aluop_s     = ALUOP_ADD;
        branch_s    = 1'b0;
        branch_ne_s = 1'b0;
        illegal_s   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_s = 1'b1;
                alusrcb   = 2'b01;
                irwrite_s = mem_ready;
                pcwrite_s = mem_ready;
            end
            S_DECODE: begin
                alusrcb   = 2'b11;
                illegal_s = ~op_supported(op);
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                iord      = 1'b1;
                mem_req_s = 1'b1;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
                mem_req_s  = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop_s = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
            end
            S_BEQ: begin
                alusrca  = 1'b1;
                aluop_s  = ALUOP_SUB;
                branch_s = 1'b1;
                pcsrc    = 2'b01;
            end
`ifdef MC_BNE_EN
            S_BNE: begin
                alusrca     = 1'b1;
                aluop_s     = ALUOP_SUB;
                branch_ne_s = 1'b1;
                pcsrc       = 2'b01;
            end
`endif
            S_ADDIWB: regwrite_s = 1'b1;
            S_JUMP: begin
                pcsrc     = 2'b10;
                pcwrite_s = 1'b1;
            end
            default: begin
                mem_req_s = 1'b0;
            end
        endcase
    end

    // Reset kills every strobe in the same cycle, even though the state already reads FETCH.
    assign mem_req    = ~reset & mem_req_s;
    assign memwrite   = ~reset & memwrite_s;
    assign irwrite    = ~reset & irwrite_s;
    assign regwrite   = ~reset & regwrite_s;
    assign illegal_op = ~reset & illegal_s;
    assign pcen       = ~reset & (pcwrite_s | (branch_s & zero) | (branch_ne_s & ~zero));

    alu_decoder u_alu_decoder (
        .aluop      (aluop_s),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Randomized scoreboard bench for mc_controller: an instruction-level model queues expected
// per-cycle control vectors; a negedge monitor compares them against the DUT outputs.
module tb_mc_controller;

    localparam logic [5:0] T_LW = 6'b100011, T_SW = 6'b101011, T_RT = 6'b000000;
    localparam logic [5:0] T_BEQ = 6'b000100, T_BNE = 6'b000101, T_ADDI = 6'b001000, T_J = 6'b000010;
`ifdef MC_BNE_EN
    localparam bit BNE_ON = 1'b1;
`else
    localparam bit BNE_ON = 1'b0;
`endif

    // step ids of the reference model
    localparam int ST_RST = 0, ST_F = 1, ST_D = 2, ST_ADR = 3, ST_RD = 4, ST_RWB = 5, ST_WR = 6;
    localparam int ST_X = 7, ST_XWB = 8, ST_B = 9, ST_N = 10, ST_AIX = 11, ST_AIWB = 12, ST_J = 13;

    typedef logic [16:0] vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [5:0] op = 6'd0, funct = 6'd0;
    logic zero = 1'b0, mem_ready = 1'b0;
    logic mem_req, iord, memwrite, irwrite, pcen, regwrite, memtoreg, regdst, alusrca, illegal_op;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    vec_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen),
        .regwrite(regwrite), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    wire vec_t act = {mem_req, iord, memwrite, irwrite, pcen, regwrite, memtoreg, regdst,
                      alusrca, alusrcb, pcsrc, alucontrol, illegal_op};

    function automatic logic [2:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs of one step, straight from the per-state output list.
    function automatic vec_t model(input int st, input logic mr, input logic z,
                                   input logic [5:0] fn, input logic ill);
        logic mq = 1'b0, io = 1'b0, mw = 1'b0, ir = 1'b0, pe = 1'b0, rw = 1'b0;
        logic mt = 1'b0, rd = 1'b0, sa = 1'b0, il = 1'b0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        logic [2:0] al = 3'b010;
        case (st)
            ST_RST:  sb = 2'b01;
            ST_F:    begin mq = 1'b1; sb = 2'b01; ir = mr; pe = mr; end
            ST_D:    begin sb = 2'b11; il = ill; end
            ST_ADR, ST_AIX: begin sa = 1'b1; sb = 2'b10; end
            ST_RD:   begin io = 1'b1; mq = 1'b1; end
            ST_RWB:  begin mt = 1'b1; rw = 1'b1; end
            ST_WR:   begin io = 1'b1; mw = 1'b1; mq = 1'b1; end
            ST_X:    begin sa = 1'b1; al = funct_alu(fn); end
            ST_XWB:  begin rd = 1'b1; rw = 1'b1; end
            ST_B:    begin sa = 1'b1; al = 3'b110; ps = 2'b01; pe = z; end
            ST_N:    begin sa = 1'b1; al = 3'b110; ps = 2'b01; pe = ~z; end
            ST_AIWB: rw = 1'b1;
            ST_J:    begin ps = 2'b10; pe = 1'b1; end
            default: al = 3'b010;
        endcase
        return {mq, io, mw, ir, pe, rw, mt, rd, sa, sb, ps, al, il};
    endfunction

    task automatic cyc(input int st, input logic [5:0] o, input logic [5:0] f, input logic mr,
                       input logic z, input logic rst, input logic ill, input string n);
        @(posedge clk);
        #1;
        reset = rst; op = o; funct = f; mem_ready = mr; zero = z;
        exp_q.push_back(model(st, mr, z, f, ill));
        name_q.push_back(n);
    endtask

    // zmode: 0/1 force zero, 2 random. abort: assert reset after one stalled MEMWR cycle.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw,
                             input int zmode, input bit abort);
        int steps[$];
        logic ill = 1'b0;
        case (o)
            T_LW:    steps = {ST_F, ST_D, ST_ADR, ST_RD, ST_RWB};
            T_SW:    steps = {ST_F, ST_D, ST_ADR, ST_WR};
            T_RT:    steps = {ST_F, ST_D, ST_X, ST_XWB};
            T_BEQ:   steps = {ST_F, ST_D, ST_B};
            T_ADDI:  steps = {ST_F, ST_D, ST_AIX, ST_AIWB};
            T_J:     steps = {ST_F, ST_D, ST_J};
            default: begin
                if (BNE_ON && o == T_BNE) steps = {ST_F, ST_D, ST_N};
                else begin steps = {ST_F, ST_D}; ill = 1'b1; end
            end
        endcase
        foreach (steps[i]) begin
            int st = steps[i];
            logic z = (zmode == 2) ? logic'($urandom_range(0, 1)) : logic'(zmode[0]);
            string n = $sformatf("op%b_step%0d", o, st);
            if (st == ST_F || st == ST_RD || st == ST_WR) begin
                int waits = (st == ST_F) ? fw : mw;
                for (int w = 0; w <= waits; w++) begin
                    if (abort && st == ST_WR && w == 1) begin
                        cyc(ST_RST, o, f, 1'b1, z, 1'b1, ill, "reset_mid_memwr");
                        return;
                    end
                    cyc(st, o, f, (w == waits), z, 1'b0, ill, n);
                end
            end else begin
                cyc(st, o, f, logic'($urandom_range(0, 1)), z, 1'b0, ill, n);
            end
        end
    endtask

    // Monitor: every queued expectation is compared against the DUT mid-cycle.
    always @(negedge clk) begin
        vec_t e;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %b expected %b (mreq,iord,mw,irw,pcen,rw,m2r,rdst,asa,asb,psrc,alu,ill)",
                         n, act, e);
            end
        end
    end

    initial begin
        logic [5:0] op_tab [8];
        logic [5:0] fn_tab [5];
        op_tab = '{T_LW, T_SW, T_RT, T_BEQ, T_ADDI, T_J, T_BNE, 6'b111111};
        fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        cyc(ST_RST, 6'd0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0, "reset");
        cyc(ST_RST, 6'd0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0, "reset");

        run_instr(T_LW, 6'd0, 0, 0, 2, 1'b0);
        run_instr(T_SW, 6'd0, 0, 3, 2, 1'b0);
        run_instr(T_RT, 6'b101010, 0, 0, 2, 1'b0);
        run_instr(T_BEQ, 6'd0, 0, 0, 1, 1'b0);
        run_instr(T_BEQ, 6'd0, 0, 0, 0, 1'b0);
        run_instr(T_BNE, 6'd0, 0, 0, 0, 1'b0);
        run_instr(6'b110011, 6'd0, 1, 0, 2, 1'b0);
        run_instr(T_SW, 6'd0, 1, 3, 2, 1'b1);
        run_instr(T_ADDI, 6'd0, 2, 0, 2, 1'b0);

        repeat (250) begin
            logic [5:0] o = op_tab[$urandom_range(0, 7)];
            logic [5:0] f;
            int fw = $urandom_range(0, 2);
            int mw = $urandom_range(0, 3);
            bit ab;
            if (o == 6'b111111) o = 6'($urandom_range(0, 63));
            f = ($urandom_range(0, 1) == 0) ? fn_tab[$urandom_range(0, 4)] : 6'($urandom_range(0, 63));
            ab = (o == T_SW) && (mw >= 1) && ($urandom_range(0, 4) == 0);
            run_instr(o, f, fw, mw, 2, ab);
        end

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
